// File: rtl/tx_stream_arbiter.sv
// Packet-locked two-source AXI-Stream merger (cmd/adc) towards the Ethernet MAC, with inter-frame gap.
// Latency: grant 1 cycle after valid in IDLE, data path combinational; backpressure: m_tready feeds the granted source.
module tx_stream_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int IFG_CYCLES = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  gtx_clk_bufg,
    input  logic                  gtx_resetn,
    input  logic [DATA_WIDTH-1:0] s_cmd_tdata,
    input  logic                  s_cmd_tvalid,
    input  logic                  s_cmd_tlast,
    output logic                  s_cmd_tready,
    input  logic [DATA_WIDTH-1:0] s_adc_tdata,
    input  logic                  s_adc_tvalid,
    input  logic                  s_adc_tlast,
    output logic                  s_adc_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  cmd_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  adc_pkt_cnt
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_CMD = 2'd1,
        SEND_ADC = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_adc;
    logic             pkt_done;

    always_comb begin
        state_d      = state_q;
        s_cmd_tready = 1'b0;
        s_adc_tready = 1'b0;
        m_tdata      = '0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        grant        = 2'b00;
        pkt_done     = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the source that did not send the previous packet wins.
                if (s_cmd_tvalid && s_adc_tvalid) begin
                    state_d = last_adc ? SEND_CMD : SEND_ADC;
                end else if (s_cmd_tvalid) begin
                    state_d = SEND_CMD;
                end else if (s_adc_tvalid) begin
                    state_d = SEND_ADC;
                end
            end
            SEND_CMD: begin
                grant        = 2'b01;
                m_tdata      = s_cmd_tdata;
                m_tvalid     = s_cmd_tvalid;
                m_tlast      = s_cmd_tlast;
                s_cmd_tready = m_tready;
                if (s_cmd_tvalid && m_tready && s_cmd_tlast) begin
                    pkt_done = 1'b1;
                    state_d  = (IFG_CYCLES > 0) ? GAP : IDLE;
                end
            end
            SEND_ADC: begin
                grant        = 2'b10;
                m_tdata      = s_adc_tdata;
                m_tvalid     = s_adc_tvalid;
                m_tlast      = s_adc_tlast;
                s_adc_tready = m_tready;
                if (s_adc_tvalid && m_tready && s_adc_tlast) begin
                    pkt_done = 1'b1;
                    state_d  = (IFG_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            state_q     <= IDLE;
            gap_cnt     <= '0;
            last_adc    <= 1'b1;
            cmd_pkt_cnt <= '0;
            adc_pkt_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (pkt_done) begin
                gap_cnt  <= GAP_LOAD;
                last_adc <= (state_q == SEND_ADC);
            end else if ((state_q == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (pkt_done && (state_q == SEND_CMD)) begin
                cmd_pkt_cnt <= cmd_pkt_cnt + CNT_WIDTH'(1);
            end
            if (pkt_done && (state_q == SEND_ADC)) begin
                adc_pkt_cnt <= adc_pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/tx_stream_arbiter.md
TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of all tdata buses.
REQ-002 Parameter IFG_CYCLES, default 12, idle cycles forced after each granted packet (0 = none).
REQ-003 Parameter CNT_WIDTH, default 16, width of per-source packet counters.
REQ-004 gtx_clk_bufg  in  1  sole clock; all logic on rising edge.
REQ-005 gtx_resetn  in  1  asynchronous active-low reset.
REQ-006 s_cmd_tdata/tvalid/tlast  in  DATA_WIDTH/1/1  command-response stream from decoder.
REQ-007 s_cmd_tready  out  1  ready to command-response source.
REQ-008 s_adc_tdata/tvalid/tlast  in  DATA_WIDTH/1/1  ADC data stream.
REQ-009 s_adc_tready  out  1  ready to ADC source.
REQ-010 m_tdata/tvalid/tlast  out  DATA_WIDTH/1/1  merged stream to Ethernet MAC TX.
REQ-011 m_tready  in  1  MAC ready.
REQ-012 grant  out  2  one-hot current owner: bit0 cmd, bit1 adc, 00 none.
REQ-013 cmd_pkt_cnt, adc_pkt_cnt  out  CNT_WIDTH each  completed packets per source.

Function
REQ-014 The block SHALL implement states IDLE, SEND_CMD, SEND_ADC, GAP.
REQ-015 In IDLE, s_*_tready, m_tvalid, m_tlast SHALL be 0, and m_tdata SHALL be 0.
REQ-016 IDLE with only s_cmd_tvalid=1 SHALL go to SEND_CMD next cycle; with only s_adc_tvalid=1, to SEND_ADC.
REQ-017 IDLE with both valid SHALL grant the source not served by the most recent packet (last_winner register); after reset, cmd wins.
REQ-018 Arbitration latency SHALL be exactly 1 cycle from valid seen in IDLE to grant asserted.
REQ-019 In SEND_x, m_tdata/m_tvalid/m_tlast SHALL combinationally equal the granted source's signals, and granted s_x_tready SHALL equal m_tready; zero added latency.
REQ-020 Non-granted s_*_tready SHALL be 0 at all times.
REQ-021 The grant SHALL be packet-locked: no switch until a beat with m_tvalid & m_tready & m_tlast.
REQ-022 On that tlast beat, last_winner SHALL update, the source's counter SHALL increment by 1, wrapping from all-ones to 0.
REQ-023 After tlast beat, next state SHALL be GAP if IFG_CYCLES>0, else IDLE.
REQ-024 GAP SHALL last exactly IFG_CYCLES cycles with all outputs as in IDLE, then go to IDLE.
REQ-025 A source deasserting tvalid mid-packet SHALL NOT lose the grant; m_tvalid follows it to 0.
REQ-026 m_tready=0 while granted SHALL stall the source (tready=0) with no beat lost or duplicated.
REQ-027 grant SHALL be 01 in SEND_CMD, 10 in SEND_ADC, 00 otherwise.

Reset
REQ-028 gtx_resetn=0 SHALL immediately force state IDLE, last_winner=adc (so cmd wins first tie), counters 0, grant 00, all tready/m_tvalid/m_tlast 0, m_tdata 0.
REQ-029 Reset asserted mid-packet SHALL abort the packet with no counter increment; after release the block restarts in IDLE.

Verification
REQ-030 Single cmd packet 38 bytes, m_tready=1, IFG_CYCLES=12 -> grant=01 one cycle after s_cmd_tvalid, 38 beats out identical, cmd_pkt_cnt=1, 12 GAP cycles, then IDLE.
REQ-031 Both sources continuously valid, 4 packets each -> output order cmd,adc,cmd,adc,...; counters end 4/4; no interleaving inside any packet.
REQ-032 m_tready toggled 0/1 every 3 cycles during ADC packet of 64 bytes 0x00..0x3F -> output beats exactly 0x00..0x3F in order, no duplicates.
REQ-033 gtx_resetn pulsed low at byte 10 of cmd packet -> outputs 0 within same cycle, cmd_pkt_cnt stays 0, next packet arbitrated normally.
REQ-034 cmd_pkt_cnt preloaded via 65535 packets (CNT_WIDTH=16) plus one -> counter wraps to 0.
REQ-035 IFG_CYCLES=0, back-to-back adc packets -> next grant one cycle after tlast beat (IDLE only).
